// File: rtl/rv32_types.sv
// Shared RV32 type definitions: machine word, integer ALU opcodes and divider opcodes.
package rv32_types;

  typedef logic [31:0] rv32_word;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,
    ALU_OP_SLTU = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9
  } int_alu_op_t;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

endpackage

// File: rtl/rv32_int_div.sv
// Iterative RV32M divider: restoring shift-subtract, one quotient bit per cycle,
// with RISC-V divide-by-zero and signed-overflow results.
module rv32_int_div
  import rv32_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  div_op_t     opsel,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // && !flush; a result transfers on a rising edge where out_valid && out_ready.
  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic        want_rem;
  logic        bypass;
  logic [31:0] bypass_val;

  logic        signed_op;
  logic        is_rem;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        ovf;
  logic [31:0] special_val;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_val;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign fsm_state = state;

  assign signed_op = (opsel == DIV_OP_DIV) || (opsel == DIV_OP_REM);
  assign is_rem    = (opsel == DIV_OP_REM) || (opsel == DIV_OP_REMU);
  assign a_mag     = (signed_op && op1[31]) ? (32'd0 - op1) : op1;
  assign b_mag     = (signed_op && op2[31]) ? (32'd0 - op2) : op2;
  assign div_zero  = (op2 == 32'd0);
  assign ovf       = signed_op && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

  always_comb begin
    special_val = 32'd0;
    if (div_zero) special_val = is_rem ? op1 : 32'hFFFF_FFFF;
    else          special_val = is_rem ? 32'd0 : 32'h8000_0000;
  end

  // Borrow out of the 33-bit subtract (diff[32]) means the trial remainder is restored.
  assign shifted   = {rem, quo[31]};
  assign diff      = shifted - {1'b0, divisor};
  assign quo_fix   = neg_q ? (32'd0 - quo) : quo;
  assign rem_fix   = neg_r ? (32'd0 - rem) : rem;
  assign final_val = bypass ? bypass_val : (want_rem ? rem_fix : quo_fix);

  // Special cases spend a single fix-up cycle in CALC (counter preloaded to 32),
  // skipping every iteration, which gives them a latency of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      result     <= 32'd0;
      cnt        <= 6'd0;
      divisor    <= 32'd0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      want_rem   <= 1'b0;
      bypass     <= 1'b0;
      bypass_val <= 32'd0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      cnt       <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state      <= ST_CALC;
            divisor    <= b_mag;
            quo        <= a_mag;
            rem        <= 32'd0;
            neg_q      <= (opsel == DIV_OP_DIV) && (op1[31] ^ op2[31]);
            neg_r      <= (opsel == DIV_OP_REM) && op1[31];
            want_rem   <= is_rem;
            bypass     <= div_zero || ovf;
            bypass_val <= special_val;
            cnt        <= (div_zero || ovf) ? 6'd32 : 6'd0;
          end
        end
        ST_CALC: begin
          if (cnt == 6'd32) begin
            result    <= final_val;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_int_div.sv
// Bench for rv32_int_div: directed vectors, expected results queued by the driver
// and checked by an independent output monitor.
module tb_rv32_int_div;
  import rv32_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  div_op_t     opsel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  fsm_state;

  localparam logic [31:0] S_IDLE = 32'd0;

  rv32_int_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opsel     (opsel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  logic        seen_valid = 1'b0;
  logic [31:0] held = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_out_valid", $sformatf("got out_valid=1 result=%08h, expected no output", result));
      end else begin
        if (!seen_valid) check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
        else             check("result_hold", result, held);
        held       = result;
        seen_valid = 1'b1;
        if (out_ready) begin
          check("result", result, exp_q[0]);
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end else begin
      seen_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) fail("in_ready_timeout", "in_ready stayed low for 100 cycles");
    in_valid = 1'b1;
    opsel    = op;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
    opsel    = div_op_t'($urandom_range(0, 3));
  endtask

  task automatic push(input logic [31:0] exp, input int lat, input int acc);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_q.push_back(acc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout", "expected result never handed over");
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail(name, "out_valid never rose within 100 cycles");
  endtask

  task automatic do_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int acc;
    start_op(op, a, b, acc);
    push(exp, lat, acc);
    wait_drain();
  endtask

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    vecs[0]  = '{DIV_OP_DIV,  32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{DIV_OP_REM,  32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[4]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
    vecs[5]  = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,          33};
    vecs[6]  = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{DIV_OP_REMU, 32'd7,          32'd0,          32'd7,          1};
    vecs[10] = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[14] = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[15] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
    vecs[16] = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
    vecs[17] = '{DIV_OP_DIV,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};

    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    op1       = 32'd0;
    op2       = 32'd0;
    opsel     = DIV_OP_DIV;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", 32'(fsm_state), S_IDLE);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // flush on the tenth CALC cycle abandons the divide
    start_op(DIV_OP_DIV, 32'd100, 32'd7, acc);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_state", 32'(fsm_state), S_IDLE);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);

    // request coinciding with flush is dropped
    in_valid = 1'b1;
    flush    = 1'b1;
    opsel    = DIV_OP_DIVU;
    op1      = 32'd1;
    op2      = 32'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_reject_state", 32'(fsm_state), S_IDLE);
    check("flush_reject_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);
    do_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // backpressure holds DONE
    out_ready = 1'b0;
    start_op(DIV_OP_DIVU, 32'd1000, 32'd10, acc);
    push(32'd100, 33, acc);
    wait_valid("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", result, 32'd100);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("bp_release_state", 32'(fsm_state), S_IDLE);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // reset mid-CALC
    start_op(DIV_OP_DIV, 32'd100, 32'd7, acc);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_calc_out_valid", 32'(out_valid), 32'd0);
    check("rst_calc_state", 32'(fsm_state), S_IDLE);
    check("rst_calc_result", result, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // reset while holding a result in DONE
    out_ready = 1'b0;
    start_op(DIV_OP_DIVU, 32'd20, 32'd4, acc);
    push(32'd5, 33, acc);
    wait_valid("rst_done_valid_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_result", result, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    do_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32_int_div.md
RV32_INT_DIV -- requirements
Module: rv32_int_div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  request present on op1/op2/opsel.
REQ-005 in_ready  out  1  block can accept a request; high only in IDLE.
REQ-006 op1  in  32 (rv32_word)  dividend.
REQ-007 op2  in  32 (rv32_word)  divisor.
REQ-008 opsel  in  div_op_t  one of DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
REQ-009 flush  in  1  pipeline kill; abandons any in-flight operation.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 result  out  32 (rv32_word)  quotient or remainder per latched opsel.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 A request SHALL be accepted when in_valid && in_ready && !flush.
- op1, op2 and opsel latched.
- Operand magnitudes and result signs computed at accept.
REQ-015 IDLE -> CALC on accept, except for the special cases in REQ-019 and REQ-020.
REQ-016 CALC SHALL run a restoring shift-subtract on 32-bit magnitudes.
- One quotient bit per cycle.
- 6-bit iteration counter.
- Exactly 32 cycles, then -> DONE.
REQ-017 Normal latency SHALL be 33 cycles: accept at edge N, out_valid high after edge N+33.
REQ-018 Sign fix-up SHALL apply to signed ops only:
- DIV: quotient negated when op1 and op2 signs differ.
- REM: remainder takes the sign of op1.
- DIVU/REMU: no fix-up.
REQ-019 Divide by zero (op2 == 0) SHALL bypass CALC and enter DONE the cycle after accept (latency 1).
- Quotient 0xFFFFFFFF (DIV and DIVU).
- Remainder = op1 (REM and REMU).
REQ-020 Signed overflow (DIV/REM, op1 = 0x80000000, op2 = 0xFFFFFFFF) SHALL bypass CALC with latency 1.
- Quotient 0x80000000.
- Remainder 0.
REQ-021 In DONE, out_valid SHALL be high and result stable until out_ready is sampled high; then -> IDLE.
- No new accept in that same cycle.
REQ-022 flush SHALL take priority over all other inputs: next state IDLE, out_valid low, no result produced.
- A simultaneous in_valid is not accepted.
REQ-023 result and out_valid SHALL be registered (no combinational path from inputs).
REQ-024 Operand changes on op1/op2/opsel after accept SHALL have no effect.

Reset
REQ-025 On rst:
- state = IDLE; out_valid = 0; result = 0; counter = 0.
- in_ready goes high the cycle after rst deasserts.
REQ-026 rst asserted mid-CALC or in DONE SHALL discard the operation with no out_valid pulse.

Structure
REQ-027 div_op_t and its encodings SHALL live in rv32_types, alongside int_alu_op_t.
REQ-028 The FSM state enum SHALL be local to the module.
REQ-029 The block SHALL be a single module with no sub-modules.
- The 33-bit subtract/compare is inline in CALC.

Verification
REQ-030 DIV 100 / 7 -> result 14 (0x0000000E), out_valid exactly 33 cycles after accept; REM 100 / 7 -> 2.
REQ-031 DIV -100 / 7 -> 0xFFFFFFF2 (-14); REM -100 / 7 -> 0xFFFFFFFE (-2); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF / 2 -> 1.
REQ-032 Divide by zero:
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5.
- out_valid 1 cycle after accept.
REQ-033 Overflow:
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM same operands -> 0.
- Latency 1.
REQ-034 Flush:
- flush at cycle 10 of CALC -> IDLE next cycle, no out_valid.
- Next request (DIVU 9 / 3) -> 3.
- in_valid with flush in the same cycle is not accepted.
REQ-035 Backpressure:
- out_ready held low 5 cycles in DONE -> result and out_valid held constant, in_ready low.
- out_ready high -> IDLE next cycle.
